// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO drain arbiter and its priority picker.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arbState;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority encoder: returns the first set request strictly after last_i,
// wrapping around, so the previous winner gets the lowest priority.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] winner_o,
    output logic          found_o
);

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[IW'((int'(last_i) + k) % N)]) begin
                winner_o = IW'((int'(last_i) + k) % N);
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of N first-word-fallthrough FIFOs into one registered
// valid/ready output stage.
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             src_enable,
    input  logic [N-1:0]             fifo_valid,
    input  logic [N-1:0][WIDTH-1:0]  fifo_data,
    output logic [N-1:0]             fifo_read,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [idx_w(N)-1:0]      out_source,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [idx_w(N)-1:0]      grant_index
);

    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(BURST);

    arbState          state_q;
    logic [IW-1:0]    grant_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IW-1:0]    out_source_q;
    logic             busy_q;

    logic [N-1:0]     req;
    logic [IW-1:0]    winner;
    logic             found;
    logic             g_valid;
    logic             g_en;
    logic             fire;
    logic             last_word;

    assign req = fifo_valid & src_enable;

    rr_priority_picker #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (req),
        .last_i   (grant_q),
        .winner_o (winner),
        .found_o  (found)
    );

    assign g_valid = fifo_valid[grant_q];
    assign g_en    = src_enable[grant_q];

    // Reading is allowed when the output slot is empty or is being emptied this cycle.
    assign fire = (state_q == ARB_GRANT) && g_valid && g_en
                  && (!out_valid_q || out_ready) && !reset;

    assign fifo_read = fire ? (N'(1) << grant_q) : '0;
    assign count_d   = count_q + 1'b1;
    assign last_word = (count_d == CW'(BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= IW'(N - 1);
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            if (fire) begin
                out_data_q   <= fifo_data[grant_q];
                out_source_q <= grant_q;
                out_valid_q  <= 1'b1;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end

            case (state_q)
                ARB_IDLE: begin
                    if (found) begin
                        grant_q <= winner;
                        count_q <= '0;
                        state_q <= ARB_GRANT;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (fire) count_q <= count_d;
                    // Backpressure alone keeps the grant; only burst end, drain or revoke exit.
                    if ((fire && last_word) || !g_valid || !g_en) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_source  = out_source_q;
    assign busy        = busy_q;
    assign grant_index = grant_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Self-checking bench: FIFO sources modelled as queues, expected drain order from a
// transaction-level round-robin model, plus directed timing scenarios.
module tb_fifo_drain_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int B = 8;

    typedef logic [W-1:0] word_q_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [N-1:0]          src_enable, fifo_valid, fifo_read;
    logic [N-1:0][W-1:0]   fifo_data;
    logic                  out_valid, out_ready, busy;
    logic [W-1:0]          out_data;
    logic [1:0]            out_source, grant_index;

    logic [N-1:0]          b_en, b_valid, b_read;
    logic [N-1:0][W-1:0]   b_data;
    logic                  b_ov, b_ready, b_busy;
    logic [W-1:0]          b_od;
    logic [1:0]            b_os, b_gi;

    word_q_t    srcq [N];
    word_q_t    mq [N];
    word_q_t    exp_d;
    logic [1:0] exp_s [$];

    int errors = 0;
    int checks = 0;

    fifo_drain_arbiter #(.N(N), .WIDTH(W), .BURST(B)) dut (
        .clk(clk), .reset(reset), .src_enable(src_enable), .fifo_valid(fifo_valid),
        .fifo_data(fifo_data), .fifo_read(fifo_read), .out_valid(out_valid),
        .out_data(out_data), .out_source(out_source), .out_ready(out_ready),
        .busy(busy), .grant_index(grant_index)
    );

    fifo_drain_arbiter #(.N(N), .WIDTH(W), .BURST(1)) dut_b1 (
        .clk(clk), .reset(reset), .src_enable(b_en), .fifo_valid(b_valid),
        .fifo_data(b_data), .fifo_read(b_read), .out_valid(b_ov),
        .out_data(b_od), .out_source(b_os), .out_ready(b_ready),
        .busy(b_busy), .grant_index(b_gi)
    );

    task automatic push(input int s, input logic [W-1:0] w);
        srcq[s].push_back(w);
        mq[s].push_back(w);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
    endtask

    // Expected output order: rotate from the last winner, take up to B words per grant.
    task automatic build_model(input logic [N-1:0] en);
        int  last;
        int  pick;
        bit  more;
        exp_d.delete();
        exp_s.delete();
        last = N - 1;
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (pick < 0 && en[c] && mq[c].size() > 0) pick = c;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                for (int n = 0; n < B && mq[pick].size() > 0; n++) begin
                    exp_d.push_back(mq[pick].pop_front());
                    exp_s.push_back(2'(pick));
                end
                last = pick;
            end
        end
    endtask

    // Called at negedge: present FIFO heads, observe pre-edge, take edge, pop read words.
    task automatic step(output logic [N-1:0] rd, output logic v, output logic acc,
                        output logic [W-1:0] d, output logic [1:0] s);
        for (int i = 0; i < N; i++) begin
            fifo_valid[i] = (srcq[i].size() > 0);
            fifo_data[i]  = (srcq[i].size() > 0) ? srcq[i][0] : '0;
        end
        #1;
        rd  = fifo_read;
        v   = out_valid;
        acc = out_valid && out_ready;
        d   = out_data;
        s   = out_source;
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        reset = 1'b1; out_ready = 1'b1; src_enable = '1;
        b_valid = '0; b_en = '1; b_ready = 1'b1; b_data = '0;
        clear_all();
        step(rd, v, a, d, s);
        step(rd, v, a, d, s);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
        checks++; if (grant_index !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d want 3", grant_index); end
        checks++; if (fifo_read !== 4'b0) begin errors++; $display("FAIL reset_read: got %b want 0000", fifo_read); end
        checks++; if (out_data !== '0 || out_source !== 2'd0) begin errors++; $display("FAIL reset_out: got %h/%0d want 0/0", out_data, out_source); end
    endtask

    task automatic test_single();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        logic [N-1:0] er;
        int accn;
        do_reset();
        for (int n = 0; n < 3; n++) push(2, 32'hA200 + n);
        build_model(4'hF);
        accn = 0;
        for (int c = 0; c < 6; c++) begin
            step(rd, v, a, d, s);
            er = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
            checks++; if (rd !== er) begin errors++; $display("FAIL single_read c%0d: got %b want %b", c, rd, er); end
            if (a) begin
                checks++;
                if (accn >= exp_d.size() || d !== exp_d[accn] || s !== exp_s[accn]) begin
                    errors++; $display("FAIL single_word %0d: got %h/%0d", accn, d, s);
                end
                accn++;
            end
        end
        checks++; if (accn != 3) begin errors++; $display("FAIL single_count: got %0d want 3", accn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0d want 0", busy); end
    endtask

    task automatic test_rotation();
        logic [N-1:0] rd, prev; logic v, a; logic [W-1:0] d; logic [1:0] s;
        int accn, gap, src;
        int run_src [$]; int run_len [$]; int run_gap [$];
        do_reset();
        for (int sidx = 0; sidx < N; sidx++)
            for (int n = 0; n < 20; n++) push(sidx, {8'(sidx), 24'(n)});
        build_model(4'hF);
        accn = 0; gap = 0; prev = '0;
        for (int c = 0; c < 200 && accn < 80; c++) begin
            step(rd, v, a, d, s);
            if (a) begin
                checks++;
                if (accn >= exp_d.size() || d !== exp_d[accn] || s !== exp_s[accn]) begin
                    errors++; $display("FAIL rot_word %0d: got %h/%0d", accn, d, s);
                end
                accn++;
            end
            if (rd == '0) gap++;
            else begin
                src = 0;
                for (int i = 0; i < N; i++) if (rd[i]) src = i;
                if (rd == prev) run_len[run_len.size()-1]++;
                else begin
                    run_src.push_back(src); run_len.push_back(1); run_gap.push_back(gap);
                end
                gap = 0;
            end
            prev = rd;
        end
        checks++; if (accn != 80) begin errors++; $display("FAIL rot_total: got %0d want 80", accn); end
        checks++; if (run_src.size() != 12) begin errors++; $display("FAIL rot_runs: got %0d want 12", run_src.size()); end
        for (int r = 0; r < 12 && r < run_src.size(); r++) begin
            checks++;
            if (run_src[r] != r % 4 || run_len[r] != ((r < 8) ? 8 : 4) || (r <= 8 && run_gap[r] != 1)) begin
                errors++;
                $display("FAIL rot_run %0d: got src%0d len%0d gap%0d want src%0d len%0d gap1",
                         r, run_src[r], run_len[r], run_gap[r], r % 4, (r < 8) ? 8 : 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        logic [W-1:0] held;
        int accn; bit stalled;
        do_reset();
        for (int n = 0; n < 8; n++) push(0, 32'hE000 + n);
        accn = 0; stalled = 1'b0;
        for (int c = 0; c < 60 && accn < 8; c++) begin
            step(rd, v, a, d, s);
            if (a) begin
                checks++; if (d !== 32'hE000 + accn) begin errors++; $display("FAIL bp_word %0d: got %h want %h", accn, d, 32'hE000 + accn); end
                accn++;
            end
            if (accn == 3 && !stalled) begin
                stalled = 1'b1;
                held = out_data;
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    step(rd, v, a, d, s);
                    checks++;
                    if (rd !== 4'b0 || d !== held || v !== 1'b1 || held !== 32'hE003) begin
                        errors++; $display("FAIL bp_stall %0d: got rd=%b data=%h v=%0d want rd=0000 data=%h", j, rd, d, v, 32'hE003);
                    end
                end
                out_ready = 1'b1;
            end
        end
        checks++; if (accn != 8) begin errors++; $display("FAIL bp_total: got %0d want 8", accn); end
    endtask

    task automatic test_enable_mask();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        int accn; bit bad;
        do_reset();
        src_enable = 4'b1101;
        for (int sidx = 0; sidx < N; sidx++)
            for (int n = 0; n < 4; n++) push(sidx, {8'h50 + 8'(sidx), 24'(n)});
        build_model(4'b1101);
        accn = 0; bad = 1'b0;
        for (int c = 0; c < 100 && accn < exp_d.size(); c++) begin
            step(rd, v, a, d, s);
            if (rd[1] || (a && s == 2'd1)) bad = 1'b1;
            if (a) begin
                checks++;
                if (d !== exp_d[accn] || s !== exp_s[accn]) begin errors++; $display("FAIL mask_word %0d: got %h/%0d want %h/%0d", accn, d, s, exp_d[accn], exp_s[accn]); end
                accn++;
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL mask_src1_granted: got 1 want 0"); end
        checks++; if (accn != 12 || srcq[1].size() != 4) begin errors++; $display("FAIL mask_counts: got %0d/%0d want 12/4", accn, srcq[1].size()); end
        src_enable = '1;
    endtask

    task automatic test_revoke();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        do_reset();
        for (int n = 0; n < 8; n++) push(0, 32'hC000 + n);
        step(rd, v, a, d, s);
        for (int c = 0; c < 2; c++) begin
            step(rd, v, a, d, s);
            checks++; if (rd !== 4'b0001) begin errors++; $display("FAIL revoke_pre %0d: got %b want 0001", c, rd); end
        end
        src_enable = 4'b1110;
        step(rd, v, a, d, s);
        checks++; if (rd !== 4'b0) begin errors++; $display("FAIL revoke_read: got %b want 0000", rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL revoke_idle: got busy=%0d want 0", busy); end
        src_enable = '1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        do_reset();
        for (int n = 0; n < 8; n++) push(0, 32'hD000 + n);
        for (int n = 0; n < 4; n++) begin push(1, 32'hD100 + n); push(3, 32'hD300 + n); end
        step(rd, v, a, d, s);
        for (int c = 0; c < 3; c++) step(rd, v, a, d, s);
        reset = 1'b1;
        step(rd, v, a, d, s);
        checks++; if (rd !== 4'b0) begin errors++; $display("FAIL rmid_read_in_reset: got %b want 0000", rd); end
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state: got v=%0d busy=%0d want 0/0", out_valid, busy); end
        checks++; if (grant_index !== 2'd3) begin errors++; $display("FAIL rmid_grant: got %0d want 3", grant_index); end
        checks++; if (fifo_read !== 4'b0) begin errors++; $display("FAIL rmid_read_after: got %b want 0000", fifo_read); end
        srcq[0].delete();
        step(rd, v, a, d, s);
        step(rd, v, a, d, s);
        checks++; if (rd !== 4'b0010) begin errors++; $display("FAIL rmid_first_grant: got %b want 0010", rd); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        do_reset();
        push(3, 32'hF300); push(3, 32'hF301);
        for (int c = 0; c < 5; c++) step(rd, v, a, d, s);
        checks++; if (grant_index !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL wrap_setup: got grant=%0d busy=%0d want 3/0", grant_index, busy); end
        push(0, 32'hF000); push(3, 32'hF302);
        step(rd, v, a, d, s);
        step(rd, v, a, d, s);
        checks++; if (rd !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", rd); end
    endtask

    task automatic test_burst1();
        logic [N-1:0] er;
        int src;
        do_reset();
        b_valid = '1;
        for (int i = 0; i < N; i++) b_data[i] = 32'hB000 + i;
        for (int k = 0; k < 10; k++) begin
            #1;
            er = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'b0;
            checks++; if (b_read !== er) begin errors++; $display("FAIL b1_read k%0d: got %b want %b", k, b_read, er); end
            if (k >= 2 && k % 2 == 0) begin
                src = ((k - 2) / 2) % 4;
                checks++;
                if (b_ov !== 1'b1 || b_os !== 2'(src) || b_od !== 32'hB000 + src) begin
                    errors++; $display("FAIL b1_out k%0d: got v=%0d src=%0d data=%h want src=%0d", k, b_ov, b_os, b_od, src);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        b_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] rd; logic v, a; logic [W-1:0] d; logic [1:0] s;
        logic [N-1:0] en;
        logic [W-1:0] pd; logic [1:0] ps; bit pstall;
        int accn, len;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            en = 4'($urandom_range(1, 15));
            src_enable = en;
            for (int sidx = 0; sidx < N; sidx++) begin
                len = $urandom_range(0, 12);
                for (int n = 0; n < len; n++) push(sidx, {8'(it), 8'(sidx), 16'($urandom)});
            end
            build_model(en);
            accn = 0; pstall = 1'b0; pd = '0; ps = '0;
            for (int c = 0; c < 400 && accn < exp_d.size(); c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step(rd, v, a, d, s);
                checks++; if ((rd & (rd - 4'd1)) != 4'b0) begin errors++; $display("FAIL rnd_onehot it%0d: got %b", it, rd); end
                if (pstall) begin
                    checks++; if (d !== pd || s !== ps) begin errors++; $display("FAIL rnd_stable it%0d: got %h/%0d want %h/%0d", it, d, s, pd, ps); end
                end
                pstall = v && !out_ready; pd = d; ps = s;
                if (a) begin
                    checks++;
                    if (d !== exp_d[accn] || s !== exp_s[accn]) begin errors++; $display("FAIL rnd_word it%0d #%0d: got %h/%0d want %h/%0d", it, accn, d, s, exp_d[accn], exp_s[accn]); end
                    accn++;
                end
            end
            checks++; if (accn != exp_d.size()) begin errors++; $display("FAIL rnd_total it%0d: got %0d want %0d", it, accn, exp_d.size()); end
            out_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step(rd, v, a, d, s);
                checks++; if (a) begin errors++; $display("FAIL rnd_extra it%0d: got word %h want none", it, d); end
            end
            for (int sidx = 0; sidx < N; sidx++) begin
                checks++; if (srcq[sidx].size() != mq[sidx].size()) begin errors++; $display("FAIL rnd_left it%0d s%0d: got %0d want %0d", it, sidx, srcq[sidx].size(), mq[sidx].size()); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; src_enable = '1;
        fifo_valid = '0; fifo_data = '0;
        b_en = '1; b_valid = '0; b_data = '0; b_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_enable_mask();
        test_revoke();
        test_reset_mid();
        test_wrap();
        test_burst1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
